irq_arb: RTL and testbench
==========================

IRQ_ARB -- requirements
Module: irq_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, meaning number of external interrupt sources; legal values 2..8.
REQ-002 SHALL have port clk_i  input  1  system clock; all sequential logic on posedge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port irq_src_i  input  NUM_SRC  raw external interrupt lines, asynchronous to clk_i.
REQ-005 SHALL have port sel_i  input  1  register access strobe.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  4  byte offset: 0x0 PENDING (RO), 0x4 ENABLE (RW), 0x8 CLAIM (R claim / W complete).
REQ-008 SHALL have port wdata_i  input  32  write data.
REQ-009 SHALL have port rdata_o  output  32  combinational read data; zero when sel_i=0, we_i=1, or the offset is unmapped.
REQ-010 SHALL have port irq_o  output  1  single interrupt request to the core interrupt controller irq_i.

Function
REQ-011 SHALL synchronise irq_src_i through two flops before any use.
REQ-012 SHALL form eligible = pending & enable[NUM_SRC-1:0]; bits of pending and enable at index >= NUM_SRC SHALL read 0.
REQ-013 SHALL select the winner from eligible by round-robin: search starts at ptr and wraps from NUM_SRC-1 to 0; ptr resets to 0.
REQ-014 SHALL encode the claim ID as winner+1; ID 0 means none.
REQ-015 SHALL implement states IDLE, ASSERT, SERVICE and GAP; irq_o SHALL be 1 only in ASSERT, and SHALL be registered.
REQ-016 SHALL use these transitions: IDLE->ASSERT when eligible!=0; ASSERT->IDLE when eligible becomes 0; ASSERT->SERVICE on a CLAIM read; SERVICE->GAP on a CLAIM write whose wdata_i[3:0] equals the claimed ID; GAP->IDLE unconditionally after 1 cycle.
REQ-017 SHALL, on a CLAIM read in ASSERT, return the current winner ID, latch it as claimed_id, and set ptr to (winner+1) mod NUM_SRC.
REQ-018 SHALL return 0 for a CLAIM read in any state other than ASSERT, with no side effect.
REQ-019 SHALL ignore a CLAIM write in SERVICE whose ID does not match claimed_id; SHALL ignore a CLAIM write in any other state.
REQ-020 SHALL, in SERVICE, hold irq_o=0 regardless of new eligible sources; GAP guarantees at least 1 low cycle between successive requests, so each interrupt gives the core a clean rising edge.
REQ-021 SHALL apply an ENABLE write from the next cycle; if this leaves eligible=0 in ASSERT, irq_o SHALL drop on the following cycle.
REQ-022 SHALL ignore writes to PENDING and to unmapped offsets.
REQ-023 SHALL recompute the winner every cycle in ASSERT; the claimed ID is the winner in the cycle of the read.

Reset
REQ-024 SHALL, on rst_n_i low, clear state to IDLE, irq_o to 0, pending, enable, ptr, claimed_id and both synchroniser stages to 0.
REQ-025 SHALL, on reset mid-SERVICE, abandon the claim; a later complete write SHALL then be ignored.

Configuration
REQ-026 SHALL, with IRQ_ARB_EDGE_EN defined, make each source edge-triggered: a synchronised rising edge sets pending; a claim clears the claimed bit; an edge in the same cycle as its clear leaves the bit set.
REQ-027 SHALL, without IRQ_ARB_EDGE_EN, make each source level-triggered: pending equals the synchronised level; a claim does not clear it; the claimed source is excluded from eligible until complete.

Structure
REQ-028 SHALL place register offsets, state encodings and the NUM_SRC maximum in param.v.
REQ-029 SHALL implement the round-robin search in one combinational sub-module irq_rr_pick (inputs eligible and ptr; outputs winner and valid).

Verification
REQ-030 SHALL verify: ENABLE=0x01, pulse src0 -> irq_o=1 at 3-4 cycles; CLAIM read returns 1; irq_o=0 next cycle; write 1 -> GAP, then IDLE.
REQ-031 SHALL verify: ENABLE=0xFF, src2 and src5 set, ptr=0 -> claims return 3 then 6; ptr then 6; src0 raised next -> claim returns 1 (wrap).
REQ-032 SHALL verify: in SERVICE for ID 3, write 4 -> stays SERVICE, irq_o=0; write 3 -> GAP, and irq_o re-asserts only after GAP if eligible.
REQ-033 SHALL verify: in ASSERT with winner src1 only, write ENABLE=0 -> irq_o=0 within 2 cycles; CLAIM read returns 0.
REQ-034 SHALL verify, EDGE_EN build: src4 rising edge in the same cycle as the src4 claim -> PENDING bit4 remains 1 after the claim.
REQ-035 SHALL verify: rst_n_i low during SERVICE -> irq_o=0 and PENDING=ENABLE=0 immediately; a later complete write has no effect.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// Shared constants for the interrupt arbiter: register offsets, FSM states
// and the largest supported source count.
package irq_arb_pkg;

    localparam int unsigned NUM_SRC_MAX = 8;
    localparam int unsigned IDX_W       = $clog2(NUM_SRC_MAX);

    localparam logic [3:0] ADDR_PENDING = 4'h0;
    localparam logic [3:0] ADDR_ENABLE  = 4'h4;
    localparam logic [3:0] ADDR_CLAIM   = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

endpackage

// File: rtl/irq_rr_pick.sv
// Round-robin picker: first set bit of eligible_i at or after ptr_i,
// wrapping from NUM_SRC-1 back to 0. Purely combinational.
module irq_rr_pick
    import irq_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    int unsigned idx;

    // Scan NUM_SRC positions starting at the pointer; keep the first hit
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!valid_o && ((eligible_i & (NUM_SRC'(1) << idx)) != '0)) begin
                valid_o  = 1'b1;
                winner_o = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_arb.sv
// Interrupt arbiter: funnels NUM_SRC asynchronous sources into a single
// registered irq_o with a claim/complete handshake and round-robin fairness.
// Optional build macro IRQ_ARB_EDGE_EN: sources are edge-triggered and a
// claim clears the pending bit; otherwise sources are level-triggered and the
// claimed source is masked until its complete write.
module irq_arb
    import irq_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               sel_i,
    input  logic               we_i,
    input  logic [3:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               irq_o
);

    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   winner;
    logic               valid;
    logic [3:0]         winner_id;
    logic [3:0]         claimed_q;
    state_e             state_q;
    logic               irq_q;
    logic               rd_en, wr_en;
    logic               claim_rd, complete_wr, enable_wr;
    logic               unused_wdata;

    assign unused_wdata = ^wdata_i;
    assign rd_en        = sel_i & ~we_i;
    assign wr_en        = sel_i & we_i;
    assign winner_id    = 4'(winner) + 4'd1;
    assign enable_wr    = wr_en && (addr_i == ADDR_ENABLE);
    assign claim_rd     = rd_en && (addr_i == ADDR_CLAIM) && (state_q == ST_ASSERT) && valid;
    assign complete_wr  = wr_en && (addr_i == ADDR_CLAIM) && (state_q == ST_SERVICE)
                          && (wdata_i[3:0] == claimed_q);

    // Two-flop synchroniser for the asynchronous source lines
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef IRQ_ARB_EDGE_EN
    logic [NUM_SRC-1:0] prev_q, pending_q, rise, clr;

    assign rise     = sync2_q & ~prev_q;
    assign clr      = claim_rd ? (NUM_SRC'(1) << winner) : '0;
    assign pending  = pending_q;
    assign eligible = pending & enable_q;

    // Edge capture; a new edge wins over a claim clear in the same cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= sync2_q;
            pending_q <= (pending_q & ~clr) | rise;
        end
    end
`else
    logic [NUM_SRC-1:0] svc_mask;

    // Level source stays pending while serviced, so hide it until complete
    assign pending  = sync2_q;
    assign svc_mask = (state_q == ST_SERVICE) ? (NUM_SRC'(1) << (claimed_q - 4'd1)) : '0;
    assign eligible = pending & enable_q & ~svc_mask;
`endif

    irq_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (winner),
        .valid_o    (valid)
    );

    // Arbiter FSM with registered irq_o, plus ENABLE, pointer and claim state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            enable_q  <= '0;
            ptr_q     <= '0;
            claimed_q <= '0;
        end else begin
            irq_q <= 1'b0;
            if (enable_wr) begin
                enable_q <= wdata_i[NUM_SRC-1:0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        state_q <= ST_ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (!valid) begin
                        state_q <= ST_IDLE;
                    end else if (claim_rd) begin
                        state_q   <= ST_SERVICE;
                        claimed_q <= winner_id;
                        ptr_q     <= (32'(winner) == NUM_SRC - 1) ? '0 : winner + IDX_W'(1);
                    end else begin
                        irq_q <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (complete_wr) begin
                        state_q <= ST_GAP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_o = irq_q;

    // Combinational register read; only a CLAIM read in ASSERT yields an ID
    always_comb begin
        rdata_o = '0;
        if (rd_en) begin
            case (addr_i)
                ADDR_PENDING: rdata_o[NUM_SRC-1:0] = pending;
                ADDR_ENABLE:  rdata_o[NUM_SRC-1:0] = enable_q;
                ADDR_CLAIM: begin
                    if ((state_q == ST_ASSERT) && valid) begin
                        rdata_o[3:0] = winner_id;
                    end
                end
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arb.sv
// Directed self-checking bench for irq_arb (NUM_SRC = 8).
module tb_irq_arb;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [7:0]  irq_src_i = '0;
    logic        sel_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    irq_arb #(
        .NUM_SRC (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .irq_src_i (irq_src_i),
        .sel_i     (sel_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // All bus tasks are entered and left on a falling edge
    task automatic do_reset();
        rst_n_i   = 1'b0;
        irq_src_i = '0;
        sel_i     = 1'b0;
        we_i      = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        sel_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        @(negedge clk_i);
        sel_i   = 1'b0;
        we_i    = 1'b0;
        wdata_i = '0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
        sel_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        #1 d = rdata_o;
        @(negedge clk_i);
        sel_i = 1'b0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (irq_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq_o); end
        reg_read(4'h0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", d); end
        reg_read(4'h4, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_enable: got %h expected 0", d); end
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_claim: got %h expected 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        do_reset();
        reg_write(4'h4, 32'h0000_01A5);
        reg_read(4'h4, d);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL enable_rw: got %h expected 000000a5", d); end
        reg_write(4'h0, 32'hFF);
        reg_read(4'h0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL pending_ro: got %h expected 0", d); end
        reg_write(4'hC, 32'h0);
        reg_read(4'h4, d);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL unmapped_wr: got %h expected 000000a5", d); end
        reg_read(4'hC, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h expected 0", d); end
        sel_i = 1'b1; we_i = 1'b1; addr_i = 4'h4; wdata_i = 32'h0000_00A5;
        #1;
        checks++;
        if (rdata_o !== 32'h0) begin errors++; $display("FAIL rdata_on_write: got %h expected 0", rdata_o); end
        sel_i = 1'b0; we_i = 1'b0;
        #1;
        checks++;
        if (rdata_o !== 32'h0) begin errors++; $display("FAIL rdata_no_sel: got %h expected 0", rdata_o); end
        @(negedge clk_i);
        reg_write(4'h4, 32'h0);
    endtask

`ifdef IRQ_ARB_EDGE_EN
    task automatic test_edge_same_cycle();
        logic [31:0] d;
        int n;
        do_reset();
        reg_write(4'h4, 32'h10);
        irq_src_i[4] = 1'b1;
        wait_irq(n);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL edge_first_irq: got %0b expected 1", irq_o); end
        irq_src_i[4] = 1'b0;
        repeat (3) @(negedge clk_i);
        irq_src_i[4] = 1'b1;
        repeat (2) @(negedge clk_i);
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL edge_claim_id: got %0d expected 5", d); end
        reg_read(4'h0, d);
        checks++;
        if (d[4] !== 1'b1) begin errors++; $display("FAIL edge_pending_kept: got %0b expected 1", d[4]); end
        irq_src_i = '0;
        reg_write(4'h8, 32'd5);
    endtask
`else
    task automatic test_basic_claim();
        logic [31:0] d;
        int n;
        do_reset();
        reg_write(4'h4, 32'h01);
        irq_src_i[0] = 1'b1;
        wait_irq(n);
        checks++;
        if (irq_o !== 1'b1 || n < 3 || n > 4) begin
            errors++; $display("FAIL basic_latency: irq %0b after %0d cycles, expected 1 after 3..4", irq_o, n);
        end
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL basic_claim_id: got %0d expected 1", d); end
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL basic_irq_service: got %0b expected 0", irq_o); end
        reg_write(4'h8, 32'd1);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL basic_irq_gap: got %0b expected 0", irq_o); end
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL basic_irq_idle: got %0b expected 0", irq_o); end
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL basic_reassert: got %0b expected 1", irq_o); end
        irq_src_i = '0;
    endtask

    task automatic test_round_robin();
        logic [31:0] d;
        int n;
        do_reset();
        reg_write(4'h4, 32'hFF);
        irq_src_i = 8'h24;
        wait_irq(n);
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL rr_first: got %0d expected 3", d); end
        reg_write(4'h8, 32'd3);
        wait_irq(n);
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL rr_second: got %0d expected 6", d); end
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rr_claim_in_service: got %0d expected 0", d); end
        irq_src_i = 8'h01;
        repeat (3) @(negedge clk_i);
        reg_write(4'h8, 32'd6);
        wait_irq(n);
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL rr_wrap: got %0d expected 1", d); end
        irq_src_i = '0;
        reg_write(4'h8, 32'd1);
    endtask

    task automatic test_complete_mismatch();
        logic [31:0] d;
        logic seen_high;
        int n;
        do_reset();
        reg_write(4'h4, 32'hFF);
        irq_src_i = 8'h24;
        wait_irq(n);
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL mm_claim: got %0d expected 3", d); end
        reg_write(4'h8, 32'd4);
        seen_high = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (irq_o !== 1'b0) seen_high = 1'b1;
            @(negedge clk_i);
        end
        checks++;
        if (seen_high !== 1'b0) begin errors++; $display("FAIL mm_stays_service: irq seen %0b expected 0", seen_high); end
        reg_write(4'h8, 32'hABCD_0003);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL mm_gap_low: got %0b expected 0", irq_o); end
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL mm_idle_low: got %0b expected 0", irq_o); end
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL mm_reassert: got %0b expected 1", irq_o); end
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL mm_next_claim: got %0d expected 6", d); end
        irq_src_i = '0;
        reg_write(4'h8, 32'd6);
    endtask

    task automatic test_enable_drop();
        logic [31:0] d;
        int n;
        do_reset();
        reg_write(4'h4, 32'h02);
        irq_src_i = 8'h02;
        wait_irq(n);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL en_irq_up: got %0b expected 1", irq_o); end
        reg_write(4'h4, 32'h0);
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL en_irq_drop: got %0b expected 0", irq_o); end
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL en_claim_zero: got %0d expected 0", d); end
        irq_src_i = '0;
    endtask

    task automatic test_reset_in_service();
        logic [31:0] d;
        int n;
        do_reset();
        reg_write(4'h4, 32'h08);
        irq_src_i = 8'h08;
        wait_irq(n);
        reg_read(4'h8, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL rs_claim: got %0d expected 4", d); end
        rst_n_i = 1'b0;
        sel_i = 1'b1; we_i = 1'b0; addr_i = 4'h0;
        #1;
        checks++;
        if (irq_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++; $display("FAIL rs_pending_clear: irq %0b pending %h expected 0 0", irq_o, rdata_o);
        end
        addr_i = 4'h4;
        #1;
        checks++;
        if (rdata_o !== 32'h0) begin errors++; $display("FAIL rs_enable_clear: got %h expected 0", rdata_o); end
        sel_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        reg_write(4'h4, 32'h08);
        wait_irq(n);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL rs_claim_abandoned: got %0b expected 1", irq_o); end
        reg_write(4'h8, 32'd4);
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL rs_stale_complete: got %0b expected 1", irq_o); end
        irq_src_i = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
`ifdef IRQ_ARB_EDGE_EN
        test_edge_same_cycle();
`else
        test_basic_claim();
        test_round_robin();
        test_complete_mismatch();
        test_enable_drop();
        test_reset_in_service();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
